tis_port_arbiter: RTL and testbench

TIS_PORT_ARBITER -- requirements
Module: tis_port_arbiter

---
 rtl/tis_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_tis_port_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_port_arbiter.sv
// tis_port_arbiter: one read or write at a time over four neighbour ports, with fixed,
// ANY (round-robin) and LAST port selection plus a one-cycle done pulse.
module tis_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic [2:0]  sel,
   input  logic [7:0]  wr_data,
   input  logic [31:0] in_data,
   input  logic [3:0]  in_valid,
   output logic [3:0]  in_ready,
   output logic [7:0]  out_data,
   output logic [3:0]  out_valid,
   input  logic [3:0]  out_ready,
   output logic [7:0]  rd_data,
   output logic        done,
   output logic [1:0]  last_port,
   output logic        last_vld
);

   typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StDone} state_e;

   localparam logic [2:0] SelAny  = 3'd4;
   localparam logic [2:0] SelLast = 3'd5;
   localparam logic [2:0] SelNil  = 3'd6;

   state_e     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic [1:0] rr_rd_q, rr_rd_d;
   logic [1:0] rr_wr_q, rr_wr_d;
   logic [1:0] last_port_q, last_port_d;
   logic       last_vld_q, last_vld_d;

   logic [2:0] sel_eff;
   logic       is_any;
   logic [3:0] hs_src;
   logic [3:0] hs;
   logic [1:0] rr_start;
   logic [1:0] win;
   logic       fire;

   // First set bit of req scanning start, start+1, ... (mod 4).
   function automatic logic [1:0] rr_first(input logic [3:0] req, input logic [1:0] start);
      logic [1:0] idx;
      rr_first = start;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (req[idx]) rr_first = idx;
      end
   endfunction

   always_comb begin
      // LAST is resolved when the request is latched; last_port cannot move while waiting.
      sel_eff = sel;
      if (sel == SelLast) sel_eff = last_vld_q ? {1'b0, last_port_q} : SelNil;

      is_any   = (sel_q == SelAny);
      hs_src   = (state_q == StRdWait) ? in_valid :
                 (state_q == StWrWait) ? out_ready : 4'b0000;
      rr_start = (state_q == StRdWait) ? rr_rd_q : rr_wr_q;
      win      = is_any ? rr_first(hs_src, rr_start) : sel_q[1:0];
      hs       = 4'b0000;
      if (hs_src[win]) hs[win] = 1'b1;
      fire     = |hs;

      in_ready  = (state_q == StRdWait) ? hs : 4'b0000;
      out_valid = 4'b0000;
      if (state_q == StWrWait) out_valid = is_any ? hs : (4'b0001 << sel_q[1:0]);
      out_data  = (state_q == StWrWait) ? wr_data_q : 8'h00;
      done      = (state_q == StDone);
      rd_data   = rd_data_q;
      last_port = last_port_q;
      last_vld  = last_vld_q;
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      wr_data_d   = wr_data_q;
      rd_data_d   = rd_data_q;
      rr_rd_d     = rr_rd_q;
      rr_wr_d     = rr_wr_q;
      last_port_d = last_port_q;
      last_vld_d  = last_vld_q;
      case (state_q)
         StIdle: begin
            if (rd_req || wr_req) begin
               sel_d = sel_eff;
               if (!rd_req) wr_data_d = wr_data;
               if (sel_eff > SelAny) begin
                  state_d = StDone;
                  if (rd_req) rd_data_d = 8'h00;
               end else begin
                  state_d = rd_req ? StRdWait : StWrWait;
               end
            end
         end
         StRdWait, StWrWait: begin
            if (fire) begin
               state_d = StDone;
               if (state_q == StRdWait) rd_data_d = in_data[{win, 3'b000} +: 8];
               if (is_any) begin
                  if (state_q == StRdWait) rr_rd_d = win + 2'd1;
                  else                     rr_wr_d = win + 2'd1;
                  last_port_d = win;
                  last_vld_d  = 1'b1;
               end
            end else if (!((state_q == StRdWait) ? rd_req : wr_req)) begin
               state_d = StIdle;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         sel_q       <= 3'd0;
         wr_data_q   <= 8'h00;
         rd_data_q   <= 8'h00;
         rr_rd_q     <= 2'd0;
         rr_wr_q     <= 2'd0;
         last_port_q <= 2'd0;
         last_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         wr_data_q   <= wr_data_d;
         rd_data_q   <= rd_data_d;
         rr_rd_q     <= rr_rd_d;
         rr_wr_q     <= rr_wr_d;
         last_port_q <= last_port_d;
         last_vld_q  <= last_vld_d;
      end
   end

endmodule

// File: tb/tb_tis_port_arbiter.sv
// Bench for tis_port_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of port selection and round-robin pointers.
module tb_tis_port_arbiter;

   logic        clk;
   logic        rst;
   logic        rd_req;
   logic        wr_req;
   logic [2:0]  sel;
   logic [7:0]  wr_data;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [7:0]  rd_data;
   logic        done;
   logic [1:0]  last_port;
   logic        last_vld;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state
   int         m_rr_rd;
   int         m_rr_wr;
   int         m_last_port;
   logic       m_last_vld;
   logic [7:0] m_rd_data;

   tis_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .rd_req    (rd_req),
      .wr_req    (wr_req),
      .sel       (sel),
      .wr_data   (wr_data),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rd_data   (rd_data),
      .done      (done),
      .last_port (last_port),
      .last_vld  (last_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

   task automatic idle_inputs();
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      sel       = 3'd0;
      wr_data   = 8'h00;
      in_data   = 32'h0;
      in_valid  = 4'h0;
      out_ready = 4'h0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [27:0] obs;
      rst = 1'b1;
      idle_inputs();
      rd_req   = 1'b1;
      sel      = 3'd4;
      in_valid = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      obs = {in_ready, out_valid, done, out_data, rd_data, last_port, last_vld};
      n_total++;
      if (obs !== 28'h0) $display("FAIL reset_outputs: got %h want %h", obs, 28'h0);
      else n_pass++;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fixed_read();
      @(negedge clk);
      rd_req   = 1'b1;
      sel      = 3'd2;
      in_valid = 4'b0100;
      in_data  = 32'h005A_0000;
      #1;
      n_total++;
      if (in_ready !== 4'b0000) $display("FAIL fixed_rd_idle_ready: got %b want %b", in_ready, 4'b0000);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if (in_ready !== 4'b0100) $display("FAIL fixed_rd_ready: got %b want %b", in_ready, 4'b0100);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if ({done, rd_data, last_vld, in_ready} !== {1'b1, 8'h5A, 1'b0, 4'b0000})
         $display("FAIL fixed_rd_done: got done=%b rd=%h lv=%b rdy=%b want done=1 rd=5a lv=0 rdy=0000",
                  done, rd_data, last_vld, in_ready);
      else n_pass++;
      rd_req = 1'b0;
      @(negedge clk); #1;
      n_total++;
      if (done !== 1'b0) $display("FAIL fixed_rd_done_once: got %b want 0", done);
      else n_pass++;
   endtask

   task automatic test_any_read();
      int exp_port[3] = '{1, 3, 1};
      logic [7:0] d;
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         d        = 8'($urandom);
         rd_req   = 1'b1;
         sel      = 3'd4;
         in_valid = 4'b1010;
         in_data  = $urandom;
         in_data[exp_port[i]*8 +: 8] = d;
         @(negedge clk); #1;
         n_total++;
         if (in_ready !== 4'(1 << exp_port[i]))
            $display("FAIL any_rd_ready_%0d: got %b want %b", i, in_ready, 4'(1 << exp_port[i]));
         else n_pass++;
         @(negedge clk); #1;
         n_total++;
         if ({done, rd_data, last_port, last_vld} !== {1'b1, d, 2'(exp_port[i]), 1'b1})
            $display("FAIL any_rd_done_%0d: got done=%b rd=%h lp=%0d lv=%b want done=1 rd=%h lp=%0d lv=1",
                     i, done, rd_data, last_port, last_vld, d, exp_port[i]);
         else n_pass++;
         rd_req = 1'b0;
      end
   endtask

   task automatic test_any_write_last_read();
      @(negedge clk);
      wr_req    = 1'b1;
      sel       = 3'd4;
      wr_data   = 8'h80;
      out_ready = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_total++;
         if ({out_valid, out_data} !== {4'b0000, 8'h80})
            $display("FAIL any_wr_wait_%0d: got ov=%b od=%h want ov=0000 od=80", i, out_valid, out_data);
         else n_pass++;
      end
      @(negedge clk);
      out_ready = 4'b0100;
      #1;
      n_total++;
      if ({out_valid, out_data} !== {4'b0100, 8'h80})
         $display("FAIL any_wr_xfer: got ov=%b od=%h want ov=0100 od=80", out_valid, out_data);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if ({done, out_valid, out_data, last_port, last_vld} !== {1'b1, 4'b0000, 8'h00, 2'd2, 1'b1})
         $display("FAIL any_wr_done: got done=%b ov=%b od=%h lp=%0d lv=%b want 1 0000 00 2 1",
                  done, out_valid, out_data, last_port, last_vld);
      else n_pass++;
      wr_req    = 1'b0;
      out_ready = 4'b0000;
      @(negedge clk);
      rd_req   = 1'b1;
      sel      = 3'd5;
      in_valid = 4'b0100;
      in_data  = 32'hEE11_DDCC;
      @(negedge clk); #1;
      n_total++;
      if (in_ready !== 4'b0100) $display("FAIL last_rd_ready: got %b want %b", in_ready, 4'b0100);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if ({done, rd_data} !== {1'b1, 8'h11})
         $display("FAIL last_rd_done: got done=%b rd=%h want done=1 rd=11", done, rd_data);
      else n_pass++;
      rd_req   = 1'b0;
      in_valid = 4'b0000;
   endtask

   task automatic test_rd_wr_collision();
      @(negedge clk);
      rd_req    = 1'b1;
      wr_req    = 1'b1;
      sel       = 3'd0;
      wr_data   = 8'h3C;
      in_valid  = 4'b0001;
      in_data   = 32'h0000_0077;
      out_ready = 4'b0001;
      @(negedge clk); #1;
      n_total++;
      if ({in_ready, out_valid} !== {4'b0001, 4'b0000})
         $display("FAIL coll_rd_first: got rdy=%b ov=%b want rdy=0001 ov=0000", in_ready, out_valid);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if ({done, rd_data} !== {1'b1, 8'h77})
         $display("FAIL coll_rd_done: got done=%b rd=%h want done=1 rd=77", done, rd_data);
      else n_pass++;
      rd_req = 1'b0;
      @(negedge clk); #1;
      n_total++;
      if ({done, out_valid} !== {1'b0, 4'b0000})
         $display("FAIL coll_idle: got done=%b ov=%b want done=0 ov=0000", done, out_valid);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if ({out_valid, out_data} !== {4'b0001, 8'h3C})
         $display("FAIL coll_wr_xfer: got ov=%b od=%h want ov=0001 od=3c", out_valid, out_data);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if (done !== 1'b1) $display("FAIL coll_wr_done: got %b want 1", done);
      else n_pass++;
      idle_inputs();
   endtask

   task automatic test_nil_and_abort();
      pulse_reset();
      @(negedge clk);
      rd_req   = 1'b1;
      sel      = 3'd5;
      in_valid = 4'hF;
      in_data  = 32'hFFFF_FFFF;
      #1;
      n_total++;
      if (in_ready !== 4'b0000) $display("FAIL nil_idle_ready: got %b want 0000", in_ready);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if ({done, rd_data, in_ready, last_vld} !== {1'b1, 8'h00, 4'b0000, 1'b0})
         $display("FAIL nil_rd_done: got done=%b rd=%h rdy=%b lv=%b want 1 00 0000 0",
                  done, rd_data, in_ready, last_vld);
      else n_pass++;
      idle_inputs();
      @(negedge clk);
      wr_req  = 1'b1;
      sel     = 3'd1;
      wr_data = 8'hA5;
      @(negedge clk); #1;
      n_total++;
      if ({out_valid, out_data} !== {4'b0010, 8'hA5})
         $display("FAIL abort_wr_wait: got ov=%b od=%h want ov=0010 od=a5", out_valid, out_data);
      else n_pass++;
      #1;
      rst = 1'b1;
      #1;
      n_total++;
      if ({in_ready, out_valid, done, out_data} !== 17'h0)
         $display("FAIL abort_async: got rdy=%b ov=%b done=%b od=%h want all zero",
                  in_ready, out_valid, done, out_data);
      else n_pass++;
      @(negedge clk);
      wr_req    = 1'b0;
      out_ready = 4'hF;
      rst       = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_total++;
         if ({done, out_valid} !== {1'b0, 4'b0000})
            $display("FAIL abort_no_done_%0d: got done=%b ov=%b want done=0 ov=0000", i, done, out_valid);
         else n_pass++;
      end
      idle_inputs();
   endtask

   task automatic test_random();
      int         op_rd, s, eff, w, wait_cnt, idx;
      logic [7:0] wd;
      logic       nil, any, fired, aborted;
      logic [3:0] src, exp_hs;
      pulse_reset();
      m_rr_rd = 0; m_rr_wr = 0; m_last_port = 0; m_last_vld = 1'b0; m_rd_data = 8'h00;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         op_rd     = int'($urandom_range(0, 1));
         s         = int'($urandom_range(0, 7));
         wd        = 8'($urandom);
         rd_req    = (op_rd == 1);
         wr_req    = (op_rd == 0);
         sel       = 3'(s);
         wr_data   = wd;
         in_valid  = 4'($urandom);
         out_ready = 4'($urandom);
         in_data   = $urandom;
         #1;
         n_total++;
         if ({in_ready, out_valid, done, out_data} !== 17'h0)
            $display("FAIL rnd_idle_%0d: got rdy=%b ov=%b done=%b od=%h want all zero",
                     t, in_ready, out_valid, done, out_data);
         else n_pass++;
         eff = s;
         if (s == 5) eff = m_last_vld ? m_last_port : 6;
         nil = (eff > 4);
         any = (eff == 4);
         fired = 1'b0; aborted = 1'b0; wait_cnt = 0;
         if (nil) begin
            if (op_rd == 1) m_rd_data = 8'h00;
         end else begin
            while (!fired && !aborted) begin
               @(negedge clk);
               if ($urandom_range(0, 11) == 0) begin
                  rd_req = 1'b0; wr_req = 1'b0; in_valid = 4'h0; out_ready = 4'h0;
                  aborted = 1'b1;
               end else if (wait_cnt >= 8) begin
                  in_valid = 4'hF; out_ready = 4'hF;
               end else begin
                  in_valid  = 4'($urandom) & 4'($urandom);
                  out_ready = 4'($urandom) & 4'($urandom);
               end
               in_data = $urandom;
               #1;
               src = (op_rd == 1) ? in_valid : out_ready;
               exp_hs = 4'b0000; w = 0;
               if (any) begin
                  for (int k = 0; k < 4; k++) begin
                     idx = (((op_rd == 1) ? m_rr_rd : m_rr_wr) + k) % 4;
                     if (src[idx] && exp_hs == 4'b0000) begin exp_hs = 4'(1 << idx); w = idx; end
                  end
               end else if (src[eff]) begin
                  exp_hs = 4'(1 << eff); w = eff;
               end
               n_total++;
               if (op_rd == 1) begin
                  if ({in_ready, out_valid, out_data} !== {exp_hs, 4'b0000, 8'h00})
                     $display("FAIL rnd_rd_hs_%0d: got rdy=%b ov=%b od=%h want rdy=%b ov=0000 od=00",
                              t, in_ready, out_valid, out_data, exp_hs);
                  else n_pass++;
               end else begin
                  // A fixed write port offers data even while the neighbour is not ready.
                  if ({in_ready, out_valid, out_data} !==
                      {4'b0000, (any ? exp_hs : 4'(1 << eff)), wd})
                     $display("FAIL rnd_wr_hs_%0d: got rdy=%b ov=%b od=%h want rdy=0000 ov=%b od=%h",
                              t, in_ready, out_valid, out_data, (any ? exp_hs : 4'(1 << eff)), wd);
                  else n_pass++;
               end
               if (exp_hs != 4'b0000) begin
                  fired = 1'b1;
                  if (op_rd == 1) m_rd_data = in_data[w*8 +: 8];
                  if (any) begin
                     if (op_rd == 1) m_rr_rd = (w + 1) % 4;
                     else            m_rr_wr = (w + 1) % 4;
                     m_last_port = w;
                     m_last_vld  = 1'b1;
                  end
               end
               wait_cnt++;
            end
         end
         @(negedge clk); #1;
         n_total++;
         if ({done, rd_data, last_port, last_vld} !== {!aborted, m_rd_data, 2'(m_last_port), m_last_vld})
            $display("FAIL rnd_end_%0d: got done=%b rd=%h lp=%0d lv=%b want done=%b rd=%h lp=%0d lv=%b",
                     t, done, rd_data, last_port, last_vld, !aborted, m_rd_data, m_last_port,
                     m_last_vld);
         else n_pass++;
         rd_req = 1'b0;
         wr_req = 1'b0;
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_fixed_read();
      test_any_read();
      test_any_write_last_read();
      test_rd_wr_collision();
      test_nil_and_abort();
      test_random();
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
